instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the decode/immediate-extraction stage: accepts decoded RV32I fields (opcode, funct3, funct7, rd, rs1, rs2, 32-bit immediate) and packs them into a 32-bit instruction word.
- Checks that the immediate fits the format implied by the opcode.
- Emits the word with a sequential byte address so a program loader/test generator can stream it into instruction memory.
- Two-stage valid/ready pipeline with backpressure.

Parameters:
ADDR_W, 10, width of the emitted byte address; address wraps modulo 2^ADDR_W
BASE_ADDR, 0, address of the first emitted word after reset or start; must be a multiple of 4

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  synchronous restart: flush pipeline, address back to BASE_ADDR, count cleared
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept fields this cycle
opcode  input  7  instruction opcode
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R-type, and shift-immediate upper bits)
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
imm32  input  32  sign-extended immediate value (byte offset for B/J, full value for U)
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts word
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  byte address for out_instr
out_err  output  1  current word failed a check (out_instr is NOP)
err_code  output  3  0 none, 1 bad opcode, 2 imm out of range, 3 imm misaligned, 4 U low bits nonzero, 5 shamt out of range, 6 bad funct7
count  output  16  words emitted since reset/start, saturates at 0xFFFF

Behaviour:
- Reset (async, rst=1): both stages empty; out_valid=0, out_instr=0, out_err=0, err_code=0, out_addr=BASE_ADDR, count=0. in_ready=0 while rst is high, 1 on the first cycle after release.
- Stage 1 captures the fields on in_valid&&in_ready. Stage 2 registers the encoded word and error status. Latency: fields accepted at edge N give out_valid=1 after edge N+1. Full throughput of one word per cycle when out_ready=1.
- in_ready = !s1_valid || (!s2_valid || out_ready), i.e. stage 1 empty or able to move forward. Data advances only on handshake. out_instr, out_addr, out_err and err_code are stable while out_valid && !out_ready.
- Encoding by opcode:
  - R 0110011: funct7|rs2|rs1|f3|rd|op. funct7 must be 0000000 or 0100000, else err 6.
  - I 0010011, LOAD 0000011, JALR 1100111: imm[11:0]|rs1|f3|rd|op. Range -2048..2047, else err 2.
  - I-type shifts (f3=001/101): funct7|imm[4:0]|rs1|f3|rd|op. imm32 must be 0..31, else err 5. funct7 must be 0000000 (001 only) or 0000000/0100000 (101), else err 6.
  - STORE 0100011: imm[11:5]|rs2|rs1|f3|imm[4:0]|op. Range -2048..2047.
  - BRANCH 1100011: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op. Range -4096..4094. imm[0]=1 gives err 3.
  - JAL 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op. Range -1048576..1048574. imm[0]=1 gives err 3.
  - LUI 0110111, AUIPC 0010111: imm[31:12]|rd|op. imm[11:0]!=0 gives err 4.
  - Any other opcode: err 1.
- Error priority: 1 > 3 > 2 > 4 > 5 > 6. On any error out_instr=32'h00000013 and out_err=1. The word still consumes an address and increments count.
- Address: out_addr holds the current counter. On out_valid&&out_ready the counter advances by 4, wrapping modulo 2^ADDR_W (max-4 → 0). count advances in the same cycle, saturating.
- start=1: both stages are invalidated (in-flight words are dropped, no handshake), address=BASE_ADDR, count=0, in_ready=0 that cycle. start takes priority over a simultaneous in or out handshake; that handshake does not occur.
- rst asserted mid-stream: immediate return to the reset state; in-flight words are lost.

Test Plan:
- ADDI x1,x0,5 (op 0010011, f3 000, imm 5) with out_ready=1 → out_instr 0x00500093, out_addr 0, err 0, out_valid 2 cycles after accept.
- SW x2,8(x1) then BEQ x0,x0,-4 then JAL x1,2048, back-to-back → 0x0020A423 @0, 0xFE000EE3 @4, 0x001000EF @8; count=3.
- Errors: ADDI imm 3000 → 0x00000013, err 2. BEQ imm 6+1=7 → err 3. LUI imm 0x123 → err 4. SLLI imm 32 → err 5. Opcode 0x7F → err 1. Addresses still advance.
- Backpressure: 3 words streamed, out_ready low 3 cycles mid-stream → in_ready drops once both stages are full; outputs held stable; no loss or duplication; order preserved.
- Wrap/restart: ADDR_W=4, emit 5 words → addresses 0,4,8,12,0. Pulse start with 2 words in flight → both dropped, next word at BASE_ADDR, count=1.
- Assert rst mid-stream → all outputs at reset values asynchronously; stream resumes at address 0.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : packs decoded RV32I fields into instruction words, checks
//                 immediates, and streams words out with sequential addresses.
// Revision      : 1.0
// ============================================================================
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm32,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [2:0]        err_code,
  output logic [15:0]       count
);

  localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(4);
  localparam logic [31:0] c_NOP      = 32'h0000_0013;
  localparam logic [6:0]  c_OP_R     = 7'b0110011;
  localparam logic [6:0]  c_OP_IMM   = 7'b0010011;
  localparam logic [6:0]  c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  c_OP_JALR  = 7'b1100111;
  localparam logic [6:0]  c_OP_STORE = 7'b0100011;
  localparam logic [6:0]  c_OP_BR    = 7'b1100011;
  localparam logic [6:0]  c_OP_JAL   = 7'b1101111;
  localparam logic [6:0]  c_OP_LUI   = 7'b0110111;
  localparam logic [6:0]  c_OP_AUIPC = 7'b0010111;
  localparam logic [2:0]  c_ERR_NONE  = 3'd0;
  localparam logic [2:0]  c_ERR_OP    = 3'd1;
  localparam logic [2:0]  c_ERR_RANGE = 3'd2;
  localparam logic [2:0]  c_ERR_ALIGN = 3'd3;
  localparam logic [2:0]  c_ERR_ULOW  = 3'd4;
  localparam logic [2:0]  c_ERR_SHAMT = 3'd5;
  localparam logic [2:0]  c_ERR_F7    = 3'd6;

  logic              r_s1_valid;
  logic [6:0]        r_op;
  logic [2:0]        r_f3;
  logic [6:0]        r_f7;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [31:0]       r_imm;
  logic              r_s2_valid;
  logic [31:0]       r_instr;
  logic              r_err;
  logic [2:0]        r_code;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;

  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_s2_load;
  logic [31:0] w_enc;
  logic [2:0]  w_code;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;
  logic        w_shamt_ok;
  logic        w_f7_ok;

  assign in_ready   = !rst && !start && (!r_s1_valid || !r_s2_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
  assign w_out_fire = r_s2_valid && out_ready;

  // A value fits an N-bit signed field when all bits above N-1 equal the sign bit.
  assign w_fit12    = (&r_imm[31:11]) || !(|r_imm[31:11]);
  assign w_fit13    = (&r_imm[31:12]) || !(|r_imm[31:12]);
  assign w_fit21    = (&r_imm[31:20]) || !(|r_imm[31:20]);
  assign w_shamt_ok = !(|r_imm[31:5]);
  assign w_f7_ok    = (r_f7 == 7'b0000000) || (r_f7 == 7'b0100000);

  always_comb begin
    w_enc  = '0;
    w_code = c_ERR_NONE;
    case (r_op)
      c_OP_R: begin
        w_enc = {r_f7, r_rs2, r_rs1, r_f3, r_rd, r_op};
        if (!w_f7_ok) w_code = c_ERR_F7;
      end
      c_OP_IMM: begin
        if (r_f3 == 3'b001 || r_f3 == 3'b101) begin
          w_enc = {r_f7, r_imm[4:0], r_rs1, r_f3, r_rd, r_op};
          if (!w_shamt_ok)
            w_code = c_ERR_SHAMT;
          else if ((r_f3 == 3'b001) ? (r_f7 != 7'b0000000) : !w_f7_ok)
            w_code = c_ERR_F7;
        end else begin
          w_enc = {r_imm[11:0], r_rs1, r_f3, r_rd, r_op};
          if (!w_fit12) w_code = c_ERR_RANGE;
        end
      end
      c_OP_LOAD, c_OP_JALR: begin
        w_enc = {r_imm[11:0], r_rs1, r_f3, r_rd, r_op};
        if (!w_fit12) w_code = c_ERR_RANGE;
      end
      c_OP_STORE: begin
        w_enc = {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], r_op};
        if (!w_fit12) w_code = c_ERR_RANGE;
      end
      c_OP_BR: begin
        w_enc = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3, r_imm[4:1], r_imm[11], r_op};
        if (r_imm[0])      w_code = c_ERR_ALIGN;
        else if (!w_fit13) w_code = c_ERR_RANGE;
      end
      c_OP_JAL: begin
        w_enc = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_op};
        if (r_imm[0])      w_code = c_ERR_ALIGN;
        else if (!w_fit21) w_code = c_ERR_RANGE;
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_enc = {r_imm[31:12], r_rd, r_op};
        if (|r_imm[11:0]) w_code = c_ERR_ULOW;
      end
      default: w_code = c_ERR_OP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_op       <= '0;
      r_f3       <= '0;
      r_f7       <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_s2_valid <= 1'b0;
      r_instr    <= '0;
      r_err      <= 1'b0;
      r_code     <= c_ERR_NONE;
      r_addr     <= c_BASE;
      r_count    <= '0;
    end else if (start) begin
      // Restart drops in-flight words without handshaking them.
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_instr    <= '0;
      r_err      <= 1'b0;
      r_code     <= c_ERR_NONE;
      r_addr     <= c_BASE;
      r_count    <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_op       <= opcode;
        r_f3       <= funct3;
        r_f7       <= funct7;
        r_rd       <= rd;
        r_rs1      <= rs1;
        r_rs2      <= rs2;
        r_imm      <= imm32;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_instr    <= (w_code != c_ERR_NONE) ? c_NOP : w_enc;
        r_err      <= (w_code != c_ERR_NONE);
        r_code     <= w_code;
      end else if (w_out_fire) begin
        r_s2_valid <= 1'b0;
      end

      if (w_out_fire) begin
        r_addr <= r_addr + c_STEP;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_instr = r_instr;
  assign out_err   = r_err;
  assign err_code  = r_code;
  assign out_addr  = r_addr;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// tb_instr_encoder : scoreboard bench for instr_encoder (ADDR_W=4 to exercise wrap).
// Revision         : 1.0
// ============================================================================
module tb_instr_encoder;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        opcode = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [4:0]        rd = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [31:0]       imm32 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [2:0]        err_code;
  logic [15:0]       count;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm32(imm32),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  code;
  } exp_t;

  exp_t              sb_q[$];
  exp_t              cur_exp;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [15:0]       exp_count = '0;
  int                n_checks = 0;
  int                n_errors = 0;

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  initial begin : monitor
    exp_t              e;
    bit                hold;
    logic [31:0]       h_instr;
    logic [ADDR_W-1:0] h_addr;
    logic              h_err;
    logic [2:0]        h_code;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || start) begin
        sb_q.delete();
        exp_addr  = '0;
        exp_count = '0;
        hold      = 1'b0;
      end else begin
        if (hold) begin
          n_checks++;
          if (out_valid !== 1'b1 || out_instr !== h_instr || out_addr !== h_addr ||
              out_err !== h_err || err_code !== h_code) begin
            n_errors++;
            $display("FAIL hold_stable: got v=%0b %h @%0d err=%0b code=%0d, want v=1 %h @%0d err=%0b code=%0d",
                     out_valid, out_instr, out_addr, out_err, err_code, h_instr, h_addr, h_err, h_code);
          end
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_output: got %h @%0d, want no word", out_instr, out_addr);
          end else begin
            e = sb_q.pop_front();
            if (out_instr !== e.instr) begin
              n_errors++;
              $display("FAIL out_instr: got %h, want %h", out_instr, e.instr);
            end
            n_checks++;
            if (err_code !== e.code) begin
              n_errors++;
              $display("FAIL err_code: got %0d, want %0d", err_code, e.code);
            end
            n_checks++;
            if (out_err !== (e.code != 3'd0)) begin
              n_errors++;
              $display("FAIL out_err: got %0b, want %0b", out_err, (e.code != 3'd0));
            end
            n_checks++;
            if (out_addr !== exp_addr) begin
              n_errors++;
              $display("FAIL out_addr: got %0d, want %0d", out_addr, exp_addr);
            end
            exp_addr = exp_addr + ADDR_W'(4);
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
          end
        end
        if (in_valid && in_ready) sb_q.push_back(cur_exp);
        hold    = out_valid && !out_ready;
        h_instr = out_instr;
        h_addr  = out_addr;
        h_err   = out_err;
        h_code  = err_code;
      end
    end
  end

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic [31:0] ei, input logic [2:0] ec);
    bit ok;
    ok = 1'b0;
    opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm32 = im;
    cur_exp.instr = ei;
    cur_exp.code  = ec;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, want accept");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (sb_q.size() == 0) && !out_valid;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb_q.size());
    end
    n_checks++;
    if (count !== exp_count) begin
      n_errors++;
      $display("FAIL count: got %0d, want %0d", count, exp_count);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL start_in_ready: got %0b, want 0", in_ready);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 16'd0 || out_addr !== '0) begin
      n_errors++;
      $display("FAIL start_state: got v=%0b count=%0d addr=%0d, want 0/0/0", out_valid, count, out_addr);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_err !== 1'b0 || err_code !== 3'd0 ||
        out_addr !== '0 || count !== 16'd0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got v=%0b %h err=%0b code=%0d addr=%0d cnt=%0d rdy=%0b, want all 0",
               out_valid, out_instr, out_err, err_code, out_addr, count, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: got %0b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    send(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 3'd0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL latency_early: got out_valid=%0b, want 0", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_addr !== '0) begin
      n_errors++;
      $display("FAIL latency: got v=%0b addr=%0d, want v=1 addr=0", out_valid, out_addr);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    pulse_start();
    out_ready = 1'b1;
    send(7'h23, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 3'd0);
    send(7'h63, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE000EE3, 3'd0);
    send(7'h6F, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,       32'h001000EF, 3'd0);
    drain();
    n_checks++;
    if (count !== 16'd3) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d, want 3", count);
    end
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    send(7'h13, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3000,       32'h00000013, 3'd2);
    send(7'h63, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd7,          32'h00000013, 3'd3);
    send(7'h37, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h123,        32'h00000013, 3'd4);
    send(7'h13, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 32'd32,         32'h00000013, 3'd5);
    send(7'h7F, 3'b000, 7'h00, 5'd1, 5'd1, 5'd0, 32'd0,          32'h00000013, 3'd1);
    send(7'h33, 3'b000, 7'h01, 5'd3, 5'd1, 5'd2, 32'd0,          32'h00000013, 3'd6);
    send(7'h13, 3'b001, 7'h20, 5'd1, 5'd1, 5'd0, 32'd1,          32'h00000013, 3'd6);
    send(7'h13, 3'b101, 7'h7F, 5'd1, 5'd1, 5'd0, 32'd32,         32'h00000013, 3'd5);
    send(7'h6F, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0010_0001, 32'h00000013, 3'd3);
    send(7'h6F, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 32'h00000013, 3'd2);
    send(7'h13, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2048,       32'h00000013, 3'd2);
    send(7'h63, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4096,       32'h00000013, 3'd2);
    send(7'h13, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800, 32'h80000013, 3'd0);
    send(7'h63, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094,       32'h7E000FE3, 3'd0);
    send(7'h33, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3, 3'd0);
    send(7'h13, 3'b101, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3,          32'h40335293, 3'd0);
    send(7'h37, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h123452B7, 3'd0);
    send(7'h6F, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 32'h8000006F, 3'd0);
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 3'd0);
    send(7'h13, 3'b000, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_full: got in_ready=%0b out_valid=%0b, want 0/1", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(7'h13, 3'b000, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3, 32'h00300193, 3'd0);
    drain();
  endtask

  task automatic test_wrap_restart();
    pulse_start();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      send(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 3'd0);
    drain();
    out_ready = 1'b0;
    send(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 3'd0);
    send(7'h13, 3'b000, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 3'd0);
    pulse_start();
    out_ready = 1'b1;
    send(7'h13, 3'b000, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3, 32'h00300193, 3'd0);
    drain();
    n_checks++;
    if (count !== 16'd1) begin
      n_errors++;
      $display("FAIL restart_count: got %0d, want 1", count);
    end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    send(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 3'd0);
    send(7'h13, 3'b000, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== '0 || count !== 16'd0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got v=%0b %h addr=%0d cnt=%0d rdy=%0b, want all 0",
               out_valid, out_instr, out_addr, count, in_ready);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(7'h13, 3'b000, 7'h00, 5'd4, 5'd0, 5'd0, 32'd4, 32'h00400213, 3'd0);
    drain();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_wrap_restart();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
